// File: rtl/rob_cmd_issuer.sv
// Requests one ROB row, buffers its valid items and turns them into PRE/ACT/RD/WR under an open-page policy.
// Latency: ROB strobe 1 cycle after request; commands stall on iCmdReady with fields held; items overflowing the buffer are dropped.
module rob_cmd_issuer #(
    parameter int ROW_W  = 11,
    parameter int COL_W  = 8,
    parameter int ITEM_W = 24,
    parameter int FIFO_D = 8,
    parameter int T_RCD  = 3,
    parameter int T_RP   = 3,
    parameter int T_CCD  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iReqValid,
    input  logic [ROW_W-1:0]  iReqRow,
    output logic              oReqReady,
    output logic              oROB_Rd,
    output logic [ROW_W-1:0]  oROB_Row,
    input  logic              iROB_ItemValid,
    input  logic [ITEM_W-1:0] iROB_Item,
    input  logic              iROB_ItemEnd,
    output logic              oCmdValid,
    output logic [2:0]        oCmd,
    output logic [ROW_W-1:0]  oCmdRow,
    output logic [COL_W-1:0]  oCmdCol,
    output logic [1:0]        oCmdSize,
    input  logic              iCmdReady,
    output logic              oDone,
    output logic              oErr
);
    localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int CW = $clog2(FIFO_D + 1);
    localparam int EW = COL_W + 3;
    localparam int TW = 8;

    localparam logic [2:0] CMD_NOP = 3'b000;
    localparam logic [2:0] CMD_ACT = 3'b001;
    localparam logic [2:0] CMD_RD  = 3'b010;
    localparam logic [2:0] CMD_WR  = 3'b011;
    localparam logic [2:0] CMD_PRE = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE, S_ROBRD, S_SEQ, S_PRE, S_ACT, S_COL, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  req_row_q, req_row_d;
    logic [ROW_W-1:0]  open_row_q, open_row_d;
    logic              bank_open_q, bank_open_d;
    logic              end_seen_q, end_seen_d;
    logic              err_q, err_d;
    logic [TW-1:0]     row_tmr_q, row_tmr_d;
    logic [TW-1:0]     ccd_tmr_q, ccd_tmr_d;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [EW-1:0]     mem_q [FIFO_D];

    logic          collecting, item_ok, push, pop, col_vld;
    logic          fifo_full, fifo_empty, end_hit, end_now;
    logic [EW-1:0] push_dat, head_dat;
    logic          unused_item_bits;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_D - 1)) ? '0 : p + 1'b1;
    endfunction

    // Items are accepted from the first COLLECT cycle until the end marker.
    assign collecting = (state_q inside {S_SEQ, S_PRE, S_ACT, S_COL}) && !end_seen_q;
    assign fifo_full  = (cnt_q == CW'(FIFO_D));
    assign fifo_empty = (cnt_q == '0);
    assign item_ok    = collecting && iROB_ItemValid && iROB_Item[0];
    assign col_vld    = (state_q == S_COL) && !fifo_empty && (row_tmr_q == '0) && (ccd_tmr_q == '0);
    assign pop        = col_vld && iCmdReady;
    assign push       = item_ok && (!fifo_full || pop);
    assign cnt_d      = cnt_q + CW'(push) - CW'(pop);
    assign end_hit    = collecting && iROB_ItemValid && iROB_ItemEnd;
    assign end_now    = end_seen_q || end_hit;
    assign push_dat   = {iROB_Item[COL_W+3:COL_W+2], iROB_Item[COL_W+1], iROB_Item[COL_W:1]};
    assign head_dat   = mem_q[rd_ptr_q];
    assign oErr       = err_q;
    assign unused_item_bits = ^iROB_Item[ITEM_W-1:COL_W+4];

    always_comb begin
        state_d     = state_q;
        req_row_d   = req_row_q;
        open_row_d  = open_row_q;
        bank_open_d = bank_open_q;
        end_seen_d  = end_now;
        err_d       = err_q | (item_ok & ~push) | (iROB_ItemValid & ~collecting);
        row_tmr_d   = (row_tmr_q != '0) ? row_tmr_q - 1'b1 : row_tmr_q;
        ccd_tmr_d   = (ccd_tmr_q != '0) ? ccd_tmr_q - 1'b1 : ccd_tmr_q;
        oReqReady   = 1'b0;
        oROB_Rd     = 1'b0;
        oROB_Row    = '0;
        oCmdValid   = 1'b0;
        oCmd        = CMD_NOP;
        oCmdRow     = '0;
        oCmdCol     = '0;
        oCmdSize    = '0;
        oDone       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                oReqReady = ~reset;
                if (iReqValid) begin
                    req_row_d  = iReqRow;
                    end_seen_d = 1'b0;
                    state_d    = S_ROBRD;
                end
            end
            S_ROBRD: begin
                oROB_Rd  = 1'b1;
                oROB_Row = req_row_q;
                state_d  = S_SEQ;
            end
            S_SEQ: begin
                // Row opening waits for a real item so an all-invalid row costs no PRE/ACT.
                if (!fifo_empty) begin
                    if (bank_open_q && (open_row_q == req_row_q)) state_d = S_COL;
                    else if (bank_open_q)                         state_d = S_PRE;
                    else                                          state_d = S_ACT;
                end else if (end_now && (cnt_d == '0)) begin
                    state_d = S_DONE;
                end
            end
            S_PRE: begin
                oCmdValid = 1'b1;
                oCmd      = CMD_PRE;
                oCmdRow   = open_row_q;
                if (iCmdReady) begin
                    bank_open_d = 1'b0;
                    row_tmr_d   = TW'(T_RP - 1);
                    state_d     = S_ACT;
                end
            end
            S_ACT: begin
                oCmdValid = (row_tmr_q == '0);
                oCmd      = CMD_ACT;
                oCmdRow   = req_row_q;
                if ((row_tmr_q == '0) && iCmdReady) begin
                    bank_open_d = 1'b1;
                    open_row_d  = req_row_q;
                    row_tmr_d   = TW'(T_RCD - 1);
                    state_d     = S_COL;
                end
            end
            S_COL: begin
                oCmdValid = col_vld;
                oCmd      = head_dat[COL_W] ? CMD_WR : CMD_RD;
                oCmdCol   = head_dat[COL_W-1:0];
                oCmdSize  = head_dat[COL_W+2:COL_W+1];
                if (pop) ccd_tmr_d = TW'(T_CCD - 1);
                if (end_now && (cnt_d == '0)) state_d = S_DONE;
            end
            S_DONE: begin
                oDone   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            req_row_q   <= '0;
            open_row_q  <= '0;
            bank_open_q <= 1'b0;
            end_seen_q  <= 1'b0;
            err_q       <= 1'b0;
            row_tmr_q   <= '0;
            ccd_tmr_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_row_q   <= req_row_d;
            open_row_q  <= open_row_d;
            bank_open_q <= bank_open_d;
            end_seen_q  <= end_seen_d;
            err_q       <= err_d;
            row_tmr_q   <= row_tmr_d;
            ccd_tmr_q   <= ccd_tmr_d;
            cnt_q       <= cnt_d;
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_dat;
    end
endmodule

// File: tb/tb_rob_cmd_issuer.sv
// Directed bench for rob_cmd_issuer: cycle table for the main row flows, hand sequences for overflow/reset/stray cases.
module tb_rob_cmd_issuer;
    logic        clk = 1'b0;
    logic        reset;
    logic        iReqValid;
    logic [10:0] iReqRow;
    logic        oReqReady;
    logic        oROB_Rd;
    logic [10:0] oROB_Row;
    logic        iROB_ItemValid;
    logic [23:0] iROB_Item;
    logic        iROB_ItemEnd;
    logic        oCmdValid;
    logic [2:0]  oCmd;
    logic [10:0] oCmdRow;
    logic [7:0]  oCmdCol;
    logic [1:0]  oCmdSize;
    logic        iCmdReady;
    logic        oDone;
    logic        oErr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rob_cmd_issuer dut (
        .clk(clk), .reset(reset),
        .iReqValid(iReqValid), .iReqRow(iReqRow), .oReqReady(oReqReady),
        .oROB_Rd(oROB_Rd), .oROB_Row(oROB_Row),
        .iROB_ItemValid(iROB_ItemValid), .iROB_Item(iROB_Item), .iROB_ItemEnd(iROB_ItemEnd),
        .oCmdValid(oCmdValid), .oCmd(oCmd), .oCmdRow(oCmdRow), .oCmdCol(oCmdCol),
        .oCmdSize(oCmdSize), .iCmdReady(iCmdReady), .oDone(oDone), .oErr(oErr)
    );

    localparam logic O = 1'b0;
    localparam logic I = 1'b1;
    localparam logic [10:0] R0 = 11'h000;
    localparam logic [7:0]  C0 = 8'h00;
    localparam logic [1:0]  S0 = 2'd0;
    localparam logic [2:0]  NP = 3'd0;
    localparam logic [2:0]  AC = 3'd1;
    localparam logic [2:0]  RD = 3'd2;
    localparam logic [2:0]  WR = 3'd3;
    localparam logic [2:0]  PR = 3'd4;
    localparam int NV = 45;

    typedef struct packed {
        logic rst; logic rqv; logic [10:0] rqrow;
        logic iv; logic iok; logic [7:0] icol; logic ilos; logic [1:0] isz; logic iend; logic rdy;
        logic e_rqr; logic e_rob; logic [10:0] e_robrow;
        logic e_cv; logic [2:0] e_cmd; logic [10:0] e_row; logic [7:0] e_col; logic [1:0] e_sz;
        logic e_done; logic e_err;
    } vec_t;

    vec_t vecs [NV];

    function automatic logic [23:0] mk_item(input logic ok, input logic [7:0] col,
                                            input logic los, input logic [1:0] sz);
        logic [23:0] it;
        it        = '0;
        it[0]     = ok;
        it[8:1]   = col;
        it[9]     = los;
        it[11:10] = sz;
        return it;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iReqValid      = 1'b0;
        iReqRow        = '0;
        iROB_ItemValid = 1'b0;
        iROB_Item      = '0;
        iROB_ItemEnd   = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        reset          = v.rst;
        iReqValid      = v.rqv;
        iReqRow        = v.rqrow;
        iROB_ItemValid = v.iv;
        iROB_Item      = v.iv ? mk_item(v.iok, v.icol, v.ilos, v.isz) : 24'h0;
        iROB_ItemEnd   = v.iend;
        iCmdReady      = v.rdy;
    endtask

    task automatic wait_vld(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (oCmdValid) ok = 1'b1;
            else tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        bit seen;
        // reset, then bank closed: row 0x012 with RD 0x10, WR 0x14, RD 0x18
        vecs[0]  = '{I,O,R0,O,O,C0,O,S0,O,I,          O,O,R0,O,NP,R0,C0,S0,O,O};
        vecs[1]  = '{I,O,R0,O,O,C0,O,S0,O,I,          O,O,R0,O,NP,R0,C0,S0,O,O};
        vecs[2]  = '{O,O,R0,O,O,C0,O,S0,O,I,          I,O,R0,O,NP,R0,C0,S0,O,O};
        vecs[3]  = '{O,O,R0,O,O,C0,O,S0,O,I,          I,O,R0,O,NP,R0,C0,S0,O,O};
        vecs[4]  = '{O,I,11'h012,O,O,C0,O,S0,O,I,     I,O,R0,O,NP,R0,C0,S0,O,O};
        vecs[5]  = '{O,O,R0,O,O,C0,O,S0,O,I,          O,I,11'h012,O,NP,R0,C0,S0,O,O};
        vecs[6]  = '{O,O,R0,I,I,8'h10,O,2'd1,O,I,     O,O,R0,O,NP,R0,C0,S0,O,O};
        vecs[7]  = '{O,O,R0,I,I,8'h14,I,2'd0,O,I,     O,O,R0,O,NP,R0,C0,S0,O,O};
        vecs[8]  = '{O,O,R0,I,I,8'h18,O,2'd2,I,I,     O,O,R0,I,AC,11'h012,C0,S0,O,O};
        vecs[9]  = '{O,O,R0,O,O,C0,O,S0,O,I,          O,O,R0,O,NP,R0,C0,S0,O,O};
        vecs[10] = '{O,O,R0,O,O,C0,O,S0,O,I,          O,O,R0,O,NP,R0,C0,S0,O,O};
        vecs[11] = '{O,O,R0,O,O,C0,O,S0,O,I,          O,O,R0,I,RD,R0,8'h10,2'd1,O,O};
        vecs[12] = '{O,O,R0,O,O,C0,O,S0,O,I,          O,O,R0,O,NP,R0,C0,S0,O,O};
        vecs[13] = '{O,O,R0,O,O,C0,O,S0,O,I,          O,O,R0,I,WR,R0,8'h14,2'd0,O,O};
        vecs[14] = '{O,O,R0,O,O,C0,O,S0,O,I,          O,O,R0,O,NP,R0,C0,S0,O,O};
        vecs[15] = '{O,O,R0,O,O,C0,O,S0,O,I,          O,O,R0,I,RD,R0,8'h18,2'd2,O,O};
        vecs[16] = '{O,O,R0,O,O,C0,O,S0,O,I,          O,O,R0,O,NP,R0,C0,S0,I,O};
        vecs[17] = '{O,O,R0,O,O,C0,O,S0,O,I,          I,O,R0,O,NP,R0,C0,S0,O,O};
        // same row again: no PRE/ACT
        vecs[18] = '{O,I,11'h012,O,O,C0,O,S0,O,I,     I,O,R0,O,NP,R0,C0,S0,O,O};
        vecs[19] = '{O,O,R0,O,O,C0,O,S0,O,I,          O,I,11'h012,O,NP,R0,C0,S0,O,O};
        vecs[20] = '{O,O,R0,I,I,8'h20,I,2'd1,I,I,     O,O,R0,O,NP,R0,C0,S0,O,O};
        vecs[21] = '{O,O,R0,O,O,C0,O,S0,O,I,          O,O,R0,O,NP,R0,C0,S0,O,O};
        vecs[22] = '{O,O,R0,O,O,C0,O,S0,O,I,          O,O,R0,I,WR,R0,8'h20,2'd1,O,O};
        vecs[23] = '{O,O,R0,O,O,C0,O,S0,O,I,          O,O,R0,O,NP,R0,C0,S0,I,O};
        vecs[24] = '{O,O,R0,O,O,C0,O,S0,O,I,          I,O,R0,O,NP,R0,C0,S0,O,O};
        // row miss 0x055: PRE, ACT +3, RD +3 stalled 5 cycles, next RD +2
        vecs[25] = '{O,I,11'h055,O,O,C0,O,S0,O,I,     I,O,R0,O,NP,R0,C0,S0,O,O};
        vecs[26] = '{O,O,R0,O,O,C0,O,S0,O,I,          O,I,11'h055,O,NP,R0,C0,S0,O,O};
        vecs[27] = '{O,O,R0,I,I,8'h30,O,2'd1,O,I,     O,O,R0,O,NP,R0,C0,S0,O,O};
        vecs[28] = '{O,O,R0,I,I,8'h34,O,2'd3,I,I,     O,O,R0,O,NP,R0,C0,S0,O,O};
        vecs[29] = '{O,O,R0,O,O,C0,O,S0,O,I,          O,O,R0,I,PR,11'h012,C0,S0,O,O};
        vecs[30] = '{O,O,R0,O,O,C0,O,S0,O,I,          O,O,R0,O,NP,R0,C0,S0,O,O};
        vecs[31] = '{O,O,R0,O,O,C0,O,S0,O,I,          O,O,R0,O,NP,R0,C0,S0,O,O};
        vecs[32] = '{O,O,R0,O,O,C0,O,S0,O,I,          O,O,R0,I,AC,11'h055,C0,S0,O,O};
        vecs[33] = '{O,O,R0,O,O,C0,O,S0,O,I,          O,O,R0,O,NP,R0,C0,S0,O,O};
        vecs[34] = '{O,O,R0,O,O,C0,O,S0,O,I,          O,O,R0,O,NP,R0,C0,S0,O,O};
        for (int k = 35; k < 40; k++)
            vecs[k] = '{O,O,R0,O,O,C0,O,S0,O,O,       O,O,R0,I,RD,R0,8'h30,2'd1,O,O};
        vecs[40] = '{O,O,R0,O,O,C0,O,S0,O,I,          O,O,R0,I,RD,R0,8'h30,2'd1,O,O};
        vecs[41] = '{O,O,R0,O,O,C0,O,S0,O,I,          O,O,R0,O,NP,R0,C0,S0,O,O};
        vecs[42] = '{O,O,R0,O,O,C0,O,S0,O,I,          O,O,R0,I,RD,R0,8'h34,2'd3,O,O};
        vecs[43] = '{O,O,R0,O,O,C0,O,S0,O,I,          O,O,R0,O,NP,R0,C0,S0,I,O};
        vecs[44] = '{O,O,R0,O,O,C0,O,S0,O,I,          I,O,R0,O,NP,R0,C0,S0,O,O};

        reset = 1'b1;
        iCmdReady = 1'b1;
        idle();
        tick();

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i]);
            @(negedge clk);
            check($sformatf("v%0d_req_rdy", i), 32'(oReqReady), 32'(vecs[i].e_rqr));
            check($sformatf("v%0d_rob_rd", i),  32'(oROB_Rd),   32'(vecs[i].e_rob));
            check($sformatf("v%0d_rob_row", i), 32'(oROB_Row),  32'(vecs[i].e_robrow));
            check($sformatf("v%0d_cmd_vld", i), 32'(oCmdValid), 32'(vecs[i].e_cv));
            check($sformatf("v%0d_done", i),    32'(oDone),     32'(vecs[i].e_done));
            check($sformatf("v%0d_err", i),     32'(oErr),      32'(vecs[i].e_err));
            if (vecs[i].e_cv) begin
                check($sformatf("v%0d_cmd", i), 32'(oCmd), 32'(vecs[i].e_cmd));
                if (vecs[i].e_cmd == AC || vecs[i].e_cmd == PR) begin
                    check($sformatf("v%0d_cmd_row", i), 32'(oCmdRow), 32'(vecs[i].e_row));
                end else begin
                    check($sformatf("v%0d_cmd_col", i),  32'(oCmdCol),  32'(vecs[i].e_col));
                    check($sformatf("v%0d_cmd_size", i), 32'(oCmdSize), 32'(vecs[i].e_sz));
                end
            end
            tick();
        end

        // zero valid items: end marker on an invalid item
        idle();
        iCmdReady = 1'b1;
        iReqValid = 1'b1;
        iReqRow   = 11'h0AA;
        @(negedge clk);
        check("h1_req_rdy", 32'(oReqReady), 32'd1);
        tick();
        idle();
        @(negedge clk);
        check("h1_rob_rd", 32'(oROB_Rd), 32'd1);
        tick();
        iROB_ItemValid = 1'b1;
        iROB_Item      = mk_item(1'b0, 8'h44, 1'b0, 2'd0);
        iROB_ItemEnd   = 1'b1;
        @(negedge clk);
        check("h1_no_cmd_a", 32'(oCmdValid), 32'd0);
        tick();
        idle();
        @(negedge clk);
        check("h1_done", 32'(oDone), 32'd1);
        check("h1_no_cmd_b", 32'(oCmdValid), 32'd0);
        tick();
        @(negedge clk);
        check("h1_idle_rdy", 32'(oReqReady), 32'd1);
        check("h1_done_once", 32'(oDone), 32'd0);
        check("h1_err", 32'(oErr), 32'd0);
        tick();

        // overflow with command stalled on PRE, then reset mid-burst
        iCmdReady = 1'b0;
        iReqValid = 1'b1;
        iReqRow   = 11'h077;
        @(negedge clk);
        check("h2_req_rdy", 32'(oReqReady), 32'd1);
        tick();
        idle();
        tick();
        for (int i = 0; i < 9; i++) begin
            iROB_ItemValid = 1'b1;
            iROB_Item      = mk_item(1'b1, 8'(i * 4), 1'b0, 2'd0);
            iROB_ItemEnd   = 1'b0;
            @(negedge clk);
            if (i >= 2) begin
                check($sformatf("h2_pre_vld_%0d", i), 32'(oCmdValid), 32'd1);
                check($sformatf("h2_pre_cmd_%0d", i), 32'(oCmd), 32'(PR));
                check($sformatf("h2_pre_row_%0d", i), 32'(oCmdRow), 32'h055);
            end
            if (i == 8) check("h2_err_before", 32'(oErr), 32'd0);
            tick();
        end
        idle();
        @(negedge clk);
        check("h2_err_set", 32'(oErr), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("h2_rst_err", 32'(oErr), 32'd0);
        check("h2_rst_cmd_vld", 32'(oCmdValid), 32'd0);
        check("h2_rst_req_rdy", 32'(oReqReady), 32'd0);
        tick();
        reset = 1'b0;
        iCmdReady = 1'b1;
        @(negedge clk);
        check("h2_post_rst_rdy", 32'(oReqReady), 32'd1);
        check("h2_post_rst_err", 32'(oErr), 32'd0);
        tick();

        // bank closed after reset: ACT without PRE
        iReqValid = 1'b1;
        iReqRow   = 11'h099;
        tick();
        idle();
        tick();
        iROB_ItemValid = 1'b1;
        iROB_Item      = mk_item(1'b1, 8'h40, 1'b1, 2'd2);
        iROB_ItemEnd   = 1'b1;
        tick();
        idle();
        wait_vld(20, ok);
        check("h3_act_seen", 32'(ok), 32'd1);
        if (ok) begin
            check("h3_first_cmd", 32'(oCmd), 32'(AC));
            check("h3_act_row", 32'(oCmdRow), 32'h099);
            tick();
        end
        wait_vld(20, ok);
        check("h3_wr_seen", 32'(ok), 32'd1);
        if (ok) begin
            check("h3_wr_cmd", 32'(oCmd), 32'(WR));
            check("h3_wr_col", 32'(oCmdCol), 32'h40);
            check("h3_wr_size", 32'(oCmdSize), 32'd2);
            tick();
        end
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (oDone) seen = 1'b1;
            tick();
        end
        check("h3_done", 32'(seen), 32'd1);

        // item strobe while idle is a protocol error
        iROB_ItemValid = 1'b1;
        iROB_Item      = mk_item(1'b1, 8'h50, 1'b0, 2'd0);
        iROB_ItemEnd   = 1'b1;
        @(negedge clk);
        check("h4_err_before", 32'(oErr), 32'd0);
        tick();
        idle();
        @(negedge clk);
        check("h4_stray_err", 32'(oErr), 32'd1);
        check("h4_still_idle", 32'(oReqReady), 32'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
